// File: rtl/flux_frame_sequencer.sv
// Control front-end for the spectral-flux datapath: re-times the magnitude stream
// into per-bin strobes, sequences end-of-frame and qualifies beat pulses.
module flux_frame_sequencer #(
    parameter int N              = 1024,
    parameter int W              = 32,
    parameter int BIN_W          = 10,
    parameter int PIPE_LAT       = 3,
    parameter int WARMUP_FRAMES  = 32,
    parameter int REFRACT_FRAMES = 8,
    parameter int TIMEOUT        = 15,
    parameter int FC_W           = 16
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [W-1:0]     in_mag,
    input  logic             in_last,
    output logic             mag_valid,
    output logic [W-1:0]     mag_sq,
    output logic [BIN_W-1:0] bin_index,
    output logic             frame_done,
    input  logic             flux_valid,
    input  logic             beat_valid_in,
    output logic             beat_out,
    output logic [FC_W-1:0]  frame_count,
    output logic             warm,
    output logic             err_short,
    output logic             err_long,
    output logic             err_timeout,
    output logic             busy,
    output logic [1:0]       fsm_state
);

    localparam int DW = (PIPE_LAT > 1) ? $clog2(PIPE_LAT) : 1;
    localparam int TW = (TIMEOUT > 1) ? $clog2(TIMEOUT) : 1;
    localparam int RW = (REFRACT_FRAMES > 0) ? $clog2(REFRACT_FRAMES + 1) : 1;

    typedef enum logic [1:0] {IDLE, STREAM, DRAIN, WAIT_FLUX} state_t;

    state_t            state;
    state_t            state_next;
    logic [BIN_W-1:0]  bin_cnt;
    logic [DW-1:0]     drain_cnt;
    logic [TW-1:0]     timer;
    logic [RW-1:0]     refract;

    logic              xfer;
    logic              at_last_bin;
    logic              frame_end;
    logic              drain_done;
    logic              flux_take;
    logic              timeout_hit;
    logic [FC_W-1:0]   count_inc;
    logic              warm_next;
    logic              beat_next;

    // Handshake: a bin moves when in_valid and in_ready are both high at a rising edge;
    // in_ready is registered and only ever high in IDLE/STREAM.
    always_comb begin
        state_next  = state;
        xfer        = in_valid & in_ready & ((state == IDLE) | (state == STREAM));
        at_last_bin = (bin_cnt == BIN_W'(N - 1));
        frame_end   = xfer & (at_last_bin | in_last);
        drain_done  = (state == DRAIN) & (drain_cnt == DW'(PIPE_LAT - 1));
        flux_take   = (state == WAIT_FLUX) & flux_valid;
        timeout_hit = (state == WAIT_FLUX) & ~flux_valid & (timer == TW'(TIMEOUT - 1));
        count_inc   = (frame_count == '1) ? frame_count : frame_count + FC_W'(1);
        warm_next   = (count_inc >= FC_W'(WARMUP_FRAMES));
        beat_next   = flux_take & beat_valid_in & warm_next & (refract == '0);

        case (state)
            IDLE:      if (xfer) state_next = frame_end ? DRAIN : STREAM;
            STREAM:    if (frame_end) state_next = DRAIN;
            DRAIN:     if (drain_done) state_next = WAIT_FLUX;
            WAIT_FLUX: if (flux_take | timeout_hit) state_next = IDLE;
            default:   state_next = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) state <= IDLE;
        else        state <= state_next;
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            in_ready    <= 1'b0;
            mag_valid   <= 1'b0;
            mag_sq      <= '0;
            bin_index   <= '0;
            bin_cnt     <= '0;
            drain_cnt   <= '0;
            timer       <= '0;
            refract     <= '0;
            frame_done  <= 1'b0;
            beat_out    <= 1'b0;
            frame_count <= '0;
            warm        <= 1'b0;
            err_short   <= 1'b0;
            err_long    <= 1'b0;
            err_timeout <= 1'b0;
        end else begin
            in_ready  <= (state_next == IDLE) | (state_next == STREAM);
            mag_valid <= xfer;
            if (xfer) begin
                mag_sq    <= in_mag;
                bin_index <= bin_cnt;
            end

            if (frame_end)  bin_cnt <= '0;
            else if (xfer)  bin_cnt <= bin_cnt + BIN_W'(1);

            if (frame_end & at_last_bin & ~in_last) err_long  <= 1'b1;
            if (frame_end & ~at_last_bin)           err_short <= 1'b1;

            // Drain counts from the first cycle mag_valid is no longer the final strobe.
            drain_cnt  <= ((state == DRAIN) & ~drain_done) ? drain_cnt + DW'(1) : '0;
            frame_done <= drain_done;

            timer <= ((state == WAIT_FLUX) & (state_next == WAIT_FLUX)) ? timer + TW'(1) : '0;
            if (timeout_hit) err_timeout <= 1'b1;

            beat_out <= beat_next;
            if (flux_take) begin
                frame_count <= count_inc;
                warm        <= warm_next;
                if (beat_next)            refract <= RW'(REFRACT_FRAMES);
                else if (refract != '0)   refract <= refract - RW'(1);
            end
        end
    end

    assign busy      = (state != IDLE);
    assign fsm_state = state;

endmodule

// File: doc/flux_frame_sequencer.md
Name: flux_frame_sequencer

Overview:
- Control front-end for the spectral-flux datapath.
- Accepts the magnitude-squared stream from the magnitude stage over a valid/ready handshake and re-times it into per-bin strobes with a bin index.
- Waits for the datapath pipeline to drain, then issues the end-of-frame pulse, waits for the flux result and qualifies beats.
- Qualification gates beats with a warm-up window (threshold history not yet full) and a refractory period, so the autocorrelation stage only receives trustworthy beat pulses.

Parameters:
- N, 1024, bins per frame.
- W, 32, magnitude-squared width.
- BIN_W, 10, bin index width (clog2 N).
- PIPE_LAT, 3, cycles from the last mag_valid until the datapath accumulators are final.
- WARMUP_FRAMES, 32, completed frames before beats are allowed.
- REFRACT_FRAMES, 8, frames suppressed after an issued beat.
- TIMEOUT, 15, max cycles to wait for flux_valid after frame_done.
- FC_W, 16, frame counter width.

Ports:
- clk  in  1  clock
- reset  in  1  asynchronous, active-low reset
- in_valid  in  1  upstream magnitude valid
- in_ready  out  1  sequencer can accept
- in_mag  in  W  upstream magnitude squared
- in_last  in  1  upstream end-of-frame marker
- mag_valid  out  1  per-bin strobe to datapath
- mag_sq  out  W  registered magnitude to datapath
- bin_index  out  BIN_W  bin number of mag_sq
- frame_done  out  1  one-cycle end-of-frame pulse to datapath
- flux_valid  in  1  datapath result valid
- beat_valid_in  in  1  datapath raw beat flag (meaningful when flux_valid=1)
- beat_out  out  1  qualified beat pulse
- frame_count  out  FC_W  completed frames, saturating
- warm  out  1  frame_count >= WARMUP_FRAMES
- err_short  out  1  sticky: in_last seen before bin N-1
- err_long  out  1  sticky: bin N-1 accepted without in_last
- err_timeout  out  1  sticky: flux_valid missing
- busy  out  1  state != IDLE

Behaviour:
- Reset (reset=0, async): state IDLE; all outputs 0, including in_ready; bin counter, drain counter, timer and refractory counter cleared. The first clock edge after release sets in_ready=1. Reset asserted mid-frame abandons the frame; no frame_done is issued.
- States: IDLE, STREAM, DRAIN, WAIT_FLUX.
- IDLE:
  - in_ready=1.
  - A transfer (in_valid & in_ready) is bin 0 → STREAM.
- STREAM:
  - in_ready=1.
  - Each transfer registers mag_valid=1, mag_sq=in_mag, bin_index=bin counter one cycle later, then increments the counter. mag_valid=0 on cycles without a transfer.
  - Transfer at bin N-1 → DRAIN, and in_ready drops the following cycle. If in_last=0 on that transfer, set err_long.
  - Transfer with in_last=1 and bin < N-1: set err_short → DRAIN. Remaining bins are not generated.
- DRAIN:
  - in_ready=0.
  - Counts PIPE_LAT cycles after the final mag_valid cycle, then asserts frame_done for exactly 1 cycle → WAIT_FLUX.
- WAIT_FLUX:
  - in_ready=0.
  - Timer counts from frame_done.
  - On flux_valid:
    - frame_count += 1, saturating at 2^FC_W-1.
    - warm updates with the new count.
    - beat_out=1 for 1 cycle (registered, cycle after flux_valid) iff beat_valid_in & new-count warm & refract==0.
    - Issued beat loads refract=REFRACT_FRAMES. Otherwise refract decrements if nonzero.
    - Returns to IDLE.
  - Timer reaching TIMEOUT without flux_valid: set err_timeout → IDLE. frame_count is unchanged and no beat is issued.
- flux_valid outside WAIT_FLUX is ignored.
- frame_done is never asserted in the same cycle as mag_valid.
- Error flags clear only on reset.
- Minimum frame period: N + 1 + PIPE_LAT + (flux latency) + 1 cycles.

Test Plan:
- Bench parameters for all scenarios: N=8, PIPE_LAT=3, WARMUP_FRAMES=2, REFRACT_FRAMES=2.
- Nominal frame: 8 back-to-back transfers in_mag=10..17, in_last on 8th → mag_valid 8 cycles with bin_index 0..7 and mag_sq 10..17 lagging one cycle; in_ready low from the cycle after the 8th transfer; frame_done exactly 3 cycles after the last mag_valid; flux_valid 1 cycle later → frame_count=1, busy=0, in_ready=1.
- Upstream stalls: in_valid toggling 1,0,1,0 → bin_index advances only on transfers; frame_done timing is still relative to the last mag_valid.
- Warm-up and refractory: 6 frames, each with beat_valid_in=1 → beat_out is 0 in frame 1 (warm=0), 1 in frame 2, 0 in frames 3 and 4, 1 in frame 5, 0 in frame 6; warm=1 from frame 2.
- Framing errors: in_last on bin 4 → err_short=1 and frame_done follows after PIPE_LAT. A full 8 bins without in_last → err_long=1, frame still completes and frame_count increments.
- Timeout: hold flux_valid=0 → err_timeout=1 at 15 cycles after frame_done, state IDLE, frame_count unchanged; a later flux_valid is ignored.
- Async reset: assert reset at bin 5 → outputs 0 immediately without a clock edge, no frame_done; after release, a new full frame yields bin_index starting at 0 and frame_count=1.
